// File: rtl/lockstep_sched.sv
// Lockstep retirement scheduler for two cores: freezes whichever core retires first
// until its partner catches up, counts aligned retirements and aborts on a stuck partner.
module lockstep_sched #(
    parameter int MAX_INSTR     = 16,
    parameter int STALL_TIMEOUT = 64,
    parameter int PROG_BYTES    = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        retire_1_i,
    input  logic        retire_2_i,
    input  logic        fetch_1_i,
    input  logic        fetch_2_i,
    input  logic [15:0] instr_addr_1_i,
    input  logic [15:0] instr_addr_2_i,
    output logic        clk_en_1_o,
    output logic        clk_en_2_o,
    output logic        enable_1_o,
    output logic        enable_2_o,
    output logic        retire_o,
    output logic [7:0]  retired_cnt_o,
    output logic        finished_o,
    output logic        timeout_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_WAIT1   = 3'd2,
        S_WAIT2   = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    localparam logic [16:0] PROG_LIMIT = 17'(PROG_BYTES);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] stall_q, stall_d;
    logic       retire_q, retire_d;
    logic [7:0] cnt_inc;
    logic       aligned;
    logic       stall_limit;

    assign cnt_inc     = cnt_q + 8'd1;
    assign stall_limit = (int'(stall_q) == STALL_TIMEOUT - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_d  = stall_q;
        retire_d = 1'b0;
        aligned  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start_i) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                    stall_d = 8'd0;
                end
            end
            S_RUN: begin
                stall_d = 8'd0;
                if (retire_1_i && retire_2_i) aligned = 1'b1;
                else if (retire_1_i)          state_d = S_WAIT1;
                else if (retire_2_i)          state_d = S_WAIT2;
            end
            S_WAIT1, S_WAIT2: begin
                // Partner arriving on the limit cycle still counts as aligned.
                if ((state_q == S_WAIT1) ? retire_2_i : retire_1_i) aligned = 1'b1;
                else if (stall_limit)   state_d = S_TIMEOUT;
                else if (stall_q != 8'hFF) stall_d = stall_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (aligned) begin
            cnt_d    = cnt_inc;
            retire_d = 1'b1;
            stall_d  = 8'd0;
            state_d  = (int'(cnt_inc) == MAX_INSTR) ? S_DONE : S_RUN;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            stall_q  <= 8'd0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            retire_q <= retire_d;
        end
    end

    // A core is frozen while it waits for its partner.
    assign clk_en_1_o    = (state_q == S_RUN) || (state_q == S_WAIT2);
    assign clk_en_2_o    = (state_q == S_RUN) || (state_q == S_WAIT1);
    assign enable_1_o    = fetch_1_i && ({1'b0, instr_addr_1_i} < PROG_LIMIT) && clk_en_1_o;
    assign enable_2_o    = fetch_2_i && ({1'b0, instr_addr_2_i} < PROG_LIMIT) && clk_en_2_o;
    assign retire_o      = retire_q;
    assign retired_cnt_o = cnt_q;
    assign finished_o    = (state_q == S_DONE);
    assign timeout_o     = (state_q == S_TIMEOUT);
    assign state_o       = state_q;

endmodule

// File: tb/tb_lockstep_sched.sv
// Bench for lockstep_sched: directed scenarios plus a randomized phase, all checked
// every cycle against a run-level reference model and a retirement scoreboard.
module tb_lockstep_sched;

    localparam int MAX_I = 16;
    localparam int TO    = 8;
    localparam int PB    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, r1, r2, f1, f2;
    logic [15:0] a1, a2;
    logic        clk_en_1, clk_en_2, en_1, en_2, retire, finished, tout;
    logic [7:0]  cnt;
    logic [2:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    // reference model: run status, which core is parked, counts
    bit m_active, m_done, m_tout, m_pulse;
    int m_wait, m_count, m_stall;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    lockstep_sched #(.MAX_INSTR(MAX_I), .STALL_TIMEOUT(TO), .PROG_BYTES(PB)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .retire_1_i(r1), .retire_2_i(r2),
        .fetch_1_i(f1), .fetch_2_i(f2),
        .instr_addr_1_i(a1), .instr_addr_2_i(a2),
        .clk_en_1_o(clk_en_1), .clk_en_2_o(clk_en_2),
        .enable_1_o(en_1), .enable_2_o(en_2),
        .retire_o(retire), .retired_cnt_o(cnt),
        .finished_o(finished), .timeout_o(tout),
        .state_o(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_done = 0; m_tout = 0; m_pulse = 0;
        m_wait = 0; m_count = 0; m_stall = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit s, input bit i1, input bit i2);
        bit got1, got2;
        m_pulse = 0;
        if (!m_active) begin
            if (s) begin
                m_active = 1; m_done = 0; m_tout = 0;
                m_count = 0; m_stall = 0; m_wait = 0;
            end
        end else begin
            got1 = i1 || (m_wait == 1);
            got2 = i2 || (m_wait == 2);
            if (got1 && got2) begin
                m_count++;
                m_pulse = 1;
                m_wait = 0;
                m_stall = 0;
                exp_q.push_back(m_count[7:0]);
                if (m_count == MAX_I) begin
                    m_active = 0;
                    m_done = 1;
                end
            end else if (m_wait == 0) begin
                m_wait = got1 ? 1 : (got2 ? 2 : 0);
            end else if (m_stall == TO - 1) begin
                m_active = 0;
                m_tout = 1;
            end else begin
                m_stall = (m_stall < 255) ? m_stall + 1 : 255;
            end
        end
    endtask

    task automatic check_outputs();
        bit       e1, e2;
        logic [7:0] e;
        e1 = m_active && (m_wait != 1);
        e2 = m_active && (m_wait != 2);
        check("clk_en_1", 32'(clk_en_1), 32'(e1));
        check("clk_en_2", 32'(clk_en_2), 32'(e2));
        check("enable_1", 32'(en_1), 32'(f1 && (int'(a1) < PB) && e1));
        check("enable_2", 32'(en_2), 32'(f2 && (int'(a2) < PB) && e2));
        check("retire_o", 32'(retire), 32'(m_pulse));
        check("retired_cnt", 32'(cnt), 32'(m_count[7:0]));
        check("finished", 32'(finished), 32'(m_done));
        check("timeout", 32'(tout), 32'(m_tout));
        if (retire === 1'b1) n_pulses++;
        if (retire === 1'b1 || m_pulse) begin
            check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_cnt", 32'(cnt), 32'(e));
            end
        end
    endtask

    // One clock: check at the falling edge, advance model, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (rst) model_reset();
        else     model_edge(start, r1, r2);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ret(input bit i1, input bit i2);
        r1 = i1;
        r2 = i2;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // reset with every input active
        rst = 1'b1; start = 1'b1; r1 = 1'b1; r2 = 1'b1;
        f1 = 1'b1; f2 = 1'b1; a1 = 16'h0000; a2 = 16'h0004;
        model_reset();
        #2;
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        check("rst_en1", 32'(en_1), 32'd0);
        check("rst_clken2", 32'(clk_en_2), 32'd0);
        tick();
        tick();
        rst = 1'b0; start = 1'b0; set_ret(0, 0); f1 = 1'b0; f2 = 1'b0;
        repeat (3) tick();
        check("idle_after_rst", 32'(clk_en_1), 32'd0);

        // lockstep: paired retirements every third cycle
        do_start();
        for (int i = 0; i < MAX_I; i++) begin
            tick();
            tick();
            set_ret(1, 1);
            tick();
            set_ret(0, 0);
        end
        check("ls_pulse", 32'(retire), 32'd1);
        check("ls_cnt", 32'(cnt), 32'd16);
        check("ls_finished", 32'(finished), 32'd1);
        check("ls_clken", 32'({clk_en_1, clk_en_2}), 32'd0);
        set_ret(1, 1);
        tick();
        set_ret(0, 0);
        check("ls_pulses", 32'(n_pulses), 32'd16);
        check("done_hold_cnt", 32'(cnt), 32'd16);

        // skew: core 1 retires at cycle 5, core 2 at cycle 9
        do_start();
        repeat (4) tick();
        set_ret(1, 0);
        tick();
        for (int c = 6; c <= 9; c++) begin
            check("skew_clken1", 32'(clk_en_1), 32'd0);
            check("skew_clken2", 32'(clk_en_2), 32'd1);
            if (c == 9) set_ret(1, 1);
            tick();
        end
        set_ret(0, 0);
        check("skew_retire", 32'(retire), 32'd1);
        check("skew_run", 32'({clk_en_1, clk_en_2}), 32'd3);
        check("skew_cnt", 32'(cnt), 32'd1);

        // timeout: core 2 parked, core 1 never retires
        set_ret(0, 1);
        tick();
        for (int k = 1; k <= TO; k++) begin
            tick();
            if (k == TO - 1) check("to_early", 32'(tout), 32'd0);
        end
        check("to_flag", 32'(tout), 32'd1);
        check("to_clken", 32'({clk_en_1, clk_en_2}), 32'd0);
        check("to_cnt", 32'(cnt), 32'd1);
        set_ret(1, 1);
        tick();
        set_ret(0, 0);
        check("to_hold_cnt", 32'(cnt), 32'd1);

        // partner arrives on the stall-limit cycle
        do_start();
        set_ret(0, 1);
        tick();
        repeat (TO - 1) tick();
        set_ret(1, 1);
        tick();
        set_ret(0, 0);
        check("edge_retire", 32'(retire), 32'd1);
        check("edge_no_to", 32'(tout), 32'd0);
        check("edge_run", 32'({clk_en_1, clk_en_2}), 32'd3);
        check("edge_cnt", 32'(cnt), 32'd1);

        // fetch address bound
        f1 = 1'b1; a1 = 16'h003C; f2 = 1'b1; a2 = 16'h003F;
        #1;
        check("bound_in", 32'(en_1), 32'd1);
        check("bound_in2", 32'(en_2), 32'd1);
        a1 = 16'h0040;
        #1;
        check("bound_out", 32'(en_1), 32'd0);
        check("bound_fsm", 32'(clk_en_1), 32'd1);
        tick();
        f1 = 1'b0; f2 = 1'b0;

        // reset while parked in WAIT2 with count 5
        for (int i = 0; i < 4; i++) begin
            set_ret(1, 1);
            tick();
            set_ret(0, 0);
            tick();
        end
        set_ret(0, 1);
        tick();
        check("mid_cnt5", 32'(cnt), 32'd5);
        check("mid_wait2", 32'(clk_en_2), 32'd0);
        set_ret(1, 1);
        f1 = 1'b1; a1 = 16'h0000;
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_cnt", 32'(cnt), 32'd0);
        check("mid_rst_clken", 32'({clk_en_1, clk_en_2}), 32'd0);
        check("mid_rst_en", 32'(en_1), 32'd0);
        tick();
        check("mid_rst_nopulse", 32'(retire), 32'd0);
        rst = 1'b0; set_ret(0, 0); f1 = 1'b0;
        tick();
        check("mid_idle", 32'(clk_en_1), 32'd0);
        do_start();
        set_ret(1, 1);
        tick();
        set_ret(0, 0);
        check("mid_restart_pulse", 32'(retire), 32'd1);
        check("mid_restart_cnt", 32'(cnt), 32'd1);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 19) == 0);
            r1 = ($urandom_range(0, 2) == 0);
            r2 = ($urandom_range(0, 2) == 0);
            f1 = $urandom_range(0, 1) == 1;
            f2 = $urandom_range(0, 1) == 1;
            a1 = 16'($urandom_range(0, 80));
            a2 = 16'($urandom_range(0, 80));
            tick();
        end
        start = 1'b0; set_ret(0, 0);
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
